// File: rtl/imem_loader_if.sv
// Load/fetch/memory-write bundle for imem_loader.
// master: the environment (loader source, CPU fetch side, memory sink).
// slave:  the imem_loader block itself.
interface imem_loader_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = WIDTH + 24;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] ld_data;
    logic          fetch_req;
    logic          fetch_gnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic          busy;
    logic          load_done;
    logic          err;

    modport master (
        output ld_valid, ld_addr, ld_data, fetch_req,
        input  ld_ready, fetch_gnt, mem_we, mem_addr, mem_wdata,
               busy, load_done, err
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, fetch_req,
        output ld_ready, fetch_gnt, mem_we, mem_addr, mem_wdata,
               busy, load_done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts one word per handshake and writes it
// into a byte-wide memory as four little-endian byte beats, sharing the
// memory with CPU fetch (fetch wins for at most 3 cycles, then the load wins).
// Optional macro IMEM_LOADER_ALIGN_CHK_EN: reject unaligned or out-of-range
// load addresses with an err pulse instead of writing.
module imem_loader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);
    localparam int unsigned AW = WIDTH + 24;

`ifdef IMEM_LOADER_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic {IDLE, WR} state_t;

    state_t        state;
    logic [1:0]    beat;
    logic [1:0]    beat_nx;
    logic [1:0]    wait_cnt;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] data_q;
    logic          ld_win;
    logic          handshake;
    logic          reject;

    // Byte k of a word, little-endian.
    function automatic logic [WIDTH-1:0] byte_sel(input logic [AW-1:0] d, input logic [1:0] k);
        return WIDTH'(d >> {k, 3'b000});
    endfunction

    // Arbitration between a pending load and CPU fetch; grant/ready are same-cycle.
    assign ld_win        = bus.ld_valid && (!bus.fetch_req || wait_cnt == 2'd3);
    assign handshake     = !rst && (state == IDLE) && ld_win;
    assign bus.ld_ready  = handshake;
    assign bus.fetch_gnt = !rst && (state == IDLE) && bus.fetch_req && !ld_win;
    assign beat_nx       = beat + 2'd1;
    assign reject        = CHK_EN && ((bus.ld_addr[1:0] != 2'b00) ||
                                      (bus.ld_addr > AW'(DEPTH - 4)));

    // Load FSM: capture word on handshake, then emit four byte writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= 2'd0;
            wait_cnt      <= 2'd0;
            addr_q        <= '0;
            data_q        <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.load_done <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            bus.err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        wait_cnt <= 2'd0;
                        addr_q   <= bus.ld_addr;
                        data_q   <= bus.ld_data;
                        if (reject) begin
                            bus.err <= 1'b1;
                        end else begin
                            state         <= WR;
                            beat          <= 2'd0;
                            bus.mem_we    <= 1'b1;
                            bus.busy      <= 1'b1;
                            bus.mem_addr  <= bus.ld_addr;
                            bus.mem_wdata <= byte_sel(bus.ld_data, 2'd0);
                        end
                    end else if (bus.ld_valid) begin
                        wait_cnt <= (wait_cnt == 2'd3) ? 2'd3 : wait_cnt + 2'd1;
                    end else begin
                        wait_cnt <= 2'd0;
                    end
                end
                WR: begin
                    if (beat == 2'd3) begin
                        state      <= IDLE;
                        beat       <= 2'd0;
                        bus.mem_we <= 1'b0;
                        bus.busy   <= 1'b0;
                    end else begin
                        beat          <= beat_nx;
                        bus.mem_addr  <= addr_q + AW'(beat_nx);
                        bus.mem_wdata <= byte_sel(data_q, beat_nx);
                        bus.load_done <= (beat_nx == 2'd3);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: transaction-level model plus
// directed scenarios and randomized load/fetch traffic.
module tb_imem_loader;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 32;

`ifdef IMEM_LOADER_ALIGN_CHK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.WIDTH(WIDTH)) bus ();

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] q_addr[$];
    logic [7:0]  q_data[$];
    bit          q_done[$];
    int          blocked   = 0;
    logic [31:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    bit          err_exp   = 1'b0;

    // Memory image as seen on the write port.
    logic [7:0] dut_mem [DEPTH];

    function automatic bit exp_win();
        return bus.ld_valid && (!bus.fetch_req || blocked >= 3);
    endfunction

    function automatic bit rejected(input logic [31:0] a);
        return ALIGN_ON && ((a % 4) != 0 || a > DEPTH - 4);
    endfunction

    // Model advance on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr.delete(); q_data.delete(); q_done.delete();
            blocked = 0; last_addr = '0; last_data = '0; err_exp = 1'b0;
        end else if (q_addr.size() > 0) begin
            last_addr = q_addr.pop_front();
            last_data = q_data.pop_front();
            void'(q_done.pop_front());
            err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (exp_win()) begin
                blocked = 0;
                if (rejected(bus.ld_addr)) begin
                    err_exp = 1'b1;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        q_addr.push_back(bus.ld_addr + 32'(k));
                        q_data.push_back(8'((bus.ld_data >> (8 * k)) & 32'hFF));
                        q_done.push_back(k == 3);
                    end
                end
            end else if (bus.ld_valid) begin
                blocked = (blocked < 3) ? blocked + 1 : 3;
            end else begin
                blocked = 0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ld_ready",  bus.ld_ready, 0);
            chk("rst_fetch_gnt", bus.fetch_gnt, 0);
            chk("rst_mem_we",    bus.mem_we, 0);
            chk("rst_mem_addr",  bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_busy",      bus.busy, 0);
            chk("rst_load_done", bus.load_done, 0);
            chk("rst_err",       bus.err, 0);
        end else if (q_addr.size() > 0) begin
            chk("wr_ld_ready",  bus.ld_ready, 0);
            chk("wr_fetch_gnt", bus.fetch_gnt, 0);
            chk("wr_mem_we",    bus.mem_we, 1);
            chk("wr_mem_addr",  bus.mem_addr, q_addr[0]);
            chk("wr_mem_wdata", bus.mem_wdata, q_data[0]);
            chk("wr_busy",      bus.busy, 1);
            chk("wr_load_done", bus.load_done, q_done[0]);
            chk("wr_err",       bus.err, 0);
        end else begin
            chk("idle_ld_ready",  bus.ld_ready, exp_win());
            chk("idle_fetch_gnt", bus.fetch_gnt, bus.fetch_req && !exp_win());
            chk("idle_mem_we",    bus.mem_we, 0);
            chk("idle_mem_addr",  bus.mem_addr, last_addr);
            chk("idle_mem_wdata", bus.mem_wdata, last_data);
            chk("idle_busy",      bus.busy, 0);
            chk("idle_load_done", bus.load_done, 0);
            chk("idle_err",       bus.err, err_exp);
        end
        if (!rst && bus.mem_we === 1'b1 && bus.mem_addr < DEPTH)
            dut_mem[bus.mem_addr[4:0]] = bus.mem_wdata;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) dut_mem[i] = 8'hEE;
    endtask

    logic [7:0] t1b [4];
    int         hs, t0, t1;
    bit         seen_done, hs_seen;
    int         r;

    initial begin
        t1b = '{8'h13, 8'h02, 8'hA0, 8'h00};
        clear_mem();
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.fetch_req = 1'b1;

        // Reset state, with a pending fetch that must not be granted.
        repeat (2) tick();
        @(negedge clk);
        chk("t0_fetch_gnt_in_rst", bus.fetch_gnt, 0);
        chk("t0_busy_in_rst", bus.busy, 0);
        tick();
        rst = 1'b0;
        bus.fetch_req = 1'b0;
        tick();

        // Single load, little-endian byte order.
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0; bus.ld_data = 32'h00A00213;
        @(negedge clk);
        chk("t1_ready", bus.ld_ready, 1);
        tick();
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_we",   bus.mem_we, 1);
            chk("t1_addr", bus.mem_addr, 32'(k));
            chk("t1_data", bus.mem_wdata, t1b[k]);
            chk("t1_done", bus.load_done, (k == 3));
            tick();
        end
        @(negedge clk);
        chk("t1_idle_we",   bus.mem_we, 0);
        chk("t1_hold_addr", bus.mem_addr, 32'h3);
        chk("t1_hold_data", bus.mem_wdata, 8'h00);
        tick();
        for (int k = 0; k < 4; k++) chk("t1_mem", dut_mem[k], t1b[k]);

        // Fetch holds the memory for 3 cycles, then the load wins.
        bus.fetch_req = 1'b1; bus.ld_valid = 1'b1;
        bus.ld_addr = 32'h10; bus.ld_data = 32'h11223344;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t2_fetch_gnt", bus.fetch_gnt, (c < 3));
            chk("t2_ld_ready",  bus.ld_ready, (c == 3));
            tick();
            if (c == 3) bus.ld_valid = 1'b0;
        end
        bus.fetch_req = 1'b0;
        tick();

        // Back-to-back loads at a 5-cycle pitch.
        clear_mem();
        hs = 0; t0 = -1; t1 = -1;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h4; bus.ld_data = 32'hDDCCBBAA;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs_seen = bus.ld_ready && bus.ld_valid;
            if (hs_seen) begin
                if (hs == 0) t0 = c; else t1 = c;
                hs++;
            end
            tick();
            if (hs_seen && hs == 1) begin
                bus.ld_addr = 32'h8; bus.ld_data = 32'h44332211;
            end else if (hs_seen && hs == 2) begin
                bus.ld_valid = 1'b0;
            end
        end
        bus.ld_valid = 1'b0;
        chk("t3_handshakes", 64'(hs), 2);
        chk("t3_pitch", 64'(t1 - t0), 5);
        chk("t3_mem4",  dut_mem[4],  8'hAA);
        chk("t3_mem7",  dut_mem[7],  8'hDD);
        chk("t3_mem8",  dut_mem[8],  8'h11);
        chk("t3_mem11", dut_mem[11], 8'h44);

        // Reset during beat 1 aborts the write sequence.
        clear_mem();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h8; bus.ld_data = 32'h5A6B7C8D;
        @(negedge clk);
        chk("t4_ready", bus.ld_ready, 1);
        tick();
        bus.ld_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4_beat1_addr", bus.mem_addr, 32'h9);
        #1 rst = 1'b1;
        #1;
        chk("t4_we_async",   bus.mem_we, 0);
        chk("t4_busy_async", bus.busy, 0);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.load_done === 1'b1 || bus.mem_we === 1'b1) seen_done = 1'b1;
            tick();
        end
        chk("t4_no_more_writes", seen_done, 0);
        chk("t4_mem8",  dut_mem[8],  8'h8D);
        chk("t4_mem9",  dut_mem[9],  8'h7C);
        chk("t4_mem10", dut_mem[10], 8'hEE);
        chk("t4_mem11", dut_mem[11], 8'hEE);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'hC; bus.ld_data = 32'h0F0E0D0C;
        tick();
        bus.ld_valid = 1'b0;
        repeat (6) tick();
        chk("t4_next_mem12", dut_mem[12], 8'h0C);
        chk("t4_next_mem15", dut_mem[15], 8'h0F);

`ifdef IMEM_LOADER_ALIGN_CHK_EN
        // Misaligned and out-of-range loads are consumed and flagged.
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr = (i == 0) ? 32'h2 : 32'h1E;
            bus.ld_data = 32'hCAFEF00D;
            @(negedge clk);
            chk("t5_ready", bus.ld_ready, 1);
            chk("t5_err_t", bus.err, 0);
            tick();
            bus.ld_valid = 1'b0;
            @(negedge clk);
            chk("t5_err_t1", bus.err, 1);
            chk("t5_we_t1",  bus.mem_we, 0);
            tick();
            @(negedge clk);
            chk("t5_err_t2", bus.err, 0);
            chk("t5_we_t2",  bus.mem_we, 0);
            tick();
        end
`else
        // Misaligned load is written as-is.
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h2; bus.ld_data = 32'h87654321;
        @(negedge clk);
        chk("t5_ready", bus.ld_ready, 1);
        tick();
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_addr", bus.mem_addr, 32'(2 + k));
            chk("t5_err",  bus.err, 0);
            tick();
        end
        @(negedge clk);
        chk("t5_err_after", bus.err, 0);
        tick();
        chk("t5_mem2", dut_mem[2], 8'h21);
        chk("t5_mem5", dut_mem[5], 8'h87);
`endif

        // Randomized load/fetch traffic with valid held until accepted.
        hs_seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!bus.ld_valid || hs_seen) begin
                bus.ld_valid = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 9));
                if (r == 0)      bus.ld_addr = 32'hFFFF_FFFE;
                else if (r < 4)  bus.ld_addr = 32'($urandom_range(0, DEPTH - 1));
                else             bus.ld_addr = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
                bus.ld_data = $urandom;
            end
            bus.fetch_req = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs_seen = bus.ld_ready && bus.ld_valid;
            tick();
        end
        bus.ld_valid = 1'b0; bus.fetch_req = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning instruction-memory byte width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning instruction-memory depth in bytes.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset (asynchronous, active-high).
REQ-006 SHALL have port ld_valid  input  1  load word offered.
REQ-007 SHALL have port ld_ready  output  1  load word accepted this cycle when ld_valid is also high.
REQ-008 SHALL have port ld_addr  input  WIDTH+24  byte address of the word.
REQ-009 SHALL have port ld_data  input  WIDTH+24  word to store.
REQ-010 SHALL have port fetch_req  input  1  CPU requests the memory read port.
REQ-011 SHALL have port fetch_gnt  output  1  CPU owns the memory this cycle.
REQ-012 SHALL have port mem_we  output  1  byte write strobe to memory.
REQ-013 SHALL have port mem_addr  output  WIDTH+24  byte write address.
REQ-014 SHALL have port mem_wdata  output  WIDTH  byte write data.
REQ-015 SHALL have port busy  output  1  write sequence in progress.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse on the last byte write.
REQ-017 SHALL have port err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-018 SHALL implement the FSM states IDLE and WR; in WR a 2-bit beat counter runs 0..3.
REQ-019 In IDLE, fetch_gnt SHALL equal fetch_req AND NOT ld_win; ld_ready SHALL equal ld_win.
REQ-020 ld_win SHALL be ld_valid AND (NOT fetch_req OR wait_cnt==3).
REQ-021 wait_cnt (2-bit) SHALL increment, saturating at 3, each IDLE cycle with ld_valid high and ld_ready low.
REQ-022 wait_cnt SHALL clear on handshake or when ld_valid is low.
REQ-023 A load SHALL wait at most 3 cycles behind fetch_req and SHALL be accepted on the 4th cycle.
REQ-024 On handshake at cycle T, ld_addr and ld_data SHALL be registered, and the block SHALL enter WR with beat=0 at T+1.
REQ-025 In WR beat k (cycles T+1..T+4), mem_we SHALL be 1, mem_addr SHALL be addr_q+k, and mem_wdata SHALL be data_q[8k+7:8k] (little-endian).
REQ-026 load_done SHALL be 1 in beat 3 only; the FSM SHALL return to IDLE at T+5.
REQ-027 In WR, fetch_gnt and ld_ready SHALL be 0, busy SHALL be 1, and ld_valid and fetch_req SHALL be ignored.
REQ-028 In IDLE, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-029 A new load SHALL NOT be accepted earlier than T+5; back-to-back loads SHALL therefore occur at a 5-cycle pitch.
REQ-030 The address sum SHALL wrap modulo 2^(WIDTH+24).

Reset
REQ-031 While rst is high, the block SHALL asynchronously force: state IDLE, beat 0, wait_cnt 0.
REQ-032 While rst is high, the block SHALL asynchronously force to 0: mem_we, mem_addr, mem_wdata, load_done, err, busy, ld_ready, fetch_gnt.
REQ-033 Reset mid-WR SHALL abort the sequence with no further writes and no load_done; already-written bytes SHALL be left in memory.

Configuration
REQ-034 With macro IMEM_LOADER_ALIGN_CHK_EN defined, a handshake with ld_addr[1:0]!=0 or ld_addr > DEPTH-4 SHALL be rejected.
REQ-035 A rejected load SHALL be consumed, SHALL NOT enter WR, SHALL NOT raise mem_we, and SHALL pulse err at T+1.
REQ-036 With IMEM_LOADER_ALIGN_CHK_EN undefined, no check SHALL occur, every handshake SHALL enter WR, and err SHALL be tied 0.

Verification
REQ-037 Stimulus: ld_valid with addr=0x0 and data=0x00A00213, fetch_req=0.
Required response: accepted at T; writes 0x13,0x02,0xA0,0x00 to addresses 0..3 at T+1..T+4; load_done at T+4.
REQ-038 Stimulus: fetch_req held high while ld_valid is asserted at cycle 0.
Required response: fetch_gnt=1 in cycles 0..2; ld_ready=1 in cycle 3; fetch_gnt=0 in cycles 3..7.
REQ-039 Stimulus: two loads back-to-back, addr=0x4 then addr=0x8.
Required response: second handshake exactly 5 cycles after the first; 8 contiguous writes to bytes 4..11.
REQ-040 Stimulus: rst pulsed during beat 1 of a load to addr 0x8.
Required response: mem_we drops immediately; only bytes 8 and 9 are written; no load_done; next load proceeds normally.
REQ-041 Stimulus (ALIGN_CHK_EN defined): ld_addr=0x2, then ld_addr=0x1E with DEPTH=32.
Required response: each is accepted, err pulses once at T+1, and mem_we stays 0.
REQ-042 Stimulus (ALIGN_CHK_EN undefined): ld_addr=0x2.
Required response: writes go to addresses 2..5 and err stays 0.
